// File: rtl/ro_pkg.sv
// Shared constants and helpers for the readout multiplexer.
// Mode encodings and channel-index width sizing.
package ro_pkg;

    localparam logic RO_MODE_GRAY = 1'b0;
    localparam logic RO_MODE_RR   = 1'b1;

    localparam int RO_N_CH_MIN = 2;
    localparam int RO_N_CH_MAX = 16;

    // Index width never collapses below one bit, even for two channels.
    function automatic int ro_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_slot_dec.sv
// Trailing-zero slot decoder: lowest set bit index of the next count.
// An all-zero count selects the top channel, whose Gray bit toggles on wrap.
module ro_slot_dec
    import ro_pkg::*;
#(
    parameter  int N_CH = 8,
    localparam int IW   = ro_idx_w(N_CH)
) (
    input  logic [N_CH-1:0] val_i,
    output logic [IW-1:0]   idx_o
);

    always_comb begin
        idx_o = IW'(N_CH - 1);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (val_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ro_mux_n.sv
// N-channel comparator readout multiplexer with Gray (binary-weighted)
// and round-robin slot schedules, switched only at frame boundaries.
module ro_mux_n
    import ro_pkg::*;
#(
    parameter  int N_CH = 8,
    localparam int IW   = ro_idx_w(N_CH)
) (
    input  logic            clk_ext,
    input  logic            rstb,
    input  logic            en,
    input  logic            mode,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [N_CH-1:0] in,
    output logic            data_out,
    output logic [IW-1:0]   ch_id,
    output logic            valid,
    output logic            frame_start,
    output logic [N_CH-1:0] gray
);

    logic [N_CH-1:0] cnt_q,   cnt_d;
    logic [N_CH-1:0] gray_q,  gray_d;
    logic            mode_q,  mode_d;
    logic [IW-1:0]   ch_q,    ch_d;
    logic            dat_q,   dat_d;
    logic            vld_q,   vld_d;
    logic            fs_q,    fs_d;

    logic [N_CH-1:0] cnt_inc;
    logic [N_CH-1:0] cnt_nxt;
    logic [IW-1:0]   tz_idx;
    logic [IW-1:0]   slot;
    logic            wrap;

    assign cnt_inc = cnt_q + 1'b1;

    // RR wraps at N_CH; GRAY relies on natural N_CH-bit overflow.
    always_comb begin
        cnt_nxt = cnt_inc;
        if (mode_q == RO_MODE_RR && cnt_inc == N_CH'(N_CH)) begin
            cnt_nxt = '0;
        end
    end

    assign wrap = (cnt_nxt == '0);

    ro_slot_dec #(
        .N_CH (N_CH)
    ) u_dec (
        .val_i (cnt_nxt),
        .idx_o (tz_idx)
    );

    assign slot = (mode_q == RO_MODE_RR) ? cnt_nxt[IW-1:0] : tz_idx;

    always_comb begin
        cnt_d  = cnt_q;
        gray_d = gray_q;
        mode_d = mode_q;
        ch_d   = ch_q;
        dat_d  = dat_q;
        vld_d  = 1'b0;
        fs_d   = 1'b0;
        if (en) begin
            cnt_d  = cnt_nxt;
            gray_d = cnt_nxt ^ (cnt_nxt >> 1);
            ch_d   = slot;
            dat_d  = in[slot];
            vld_d  = ch_mask[slot];
            fs_d   = wrap;
            if (wrap) begin
                mode_d = mode;
            end
        end
    end

    always_ff @(posedge clk_ext or negedge rstb) begin
        if (!rstb) begin
            cnt_q  <= '0;
            gray_q <= '0;
            mode_q <= RO_MODE_GRAY;
            ch_q   <= '0;
            dat_q  <= 1'b0;
            vld_q  <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            mode_q <= mode_d;
            ch_q   <= ch_d;
            dat_q  <= dat_d;
            vld_q  <= vld_d;
            fs_q   <= fs_d;
        end
    end

    assign data_out    = dat_q;
    assign ch_id       = ch_q;
    assign valid       = vld_q;
    assign frame_start = fs_q;
    assign gray        = gray_q;

endmodule

// File: tb/tb_ro_mux_n.sv
// Scoreboard bench for ro_mux_n: 4-channel and 2-channel instances,
// directed vectors with hand-tabulated slot/Gray sequences.
`timescale 1ns/1ps
module tb_ro_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstb;
    logic       en4, mode4;
    logic [3:0] mask4, in4;
    logic       d4, v4, fs4;
    logic [1:0] ch4;
    logic [3:0] g4;

    logic       en2, mode2;
    logic [1:0] mask2, in2;
    logic       d2, v2, fs2;
    logic [0:0] ch2;
    logic [1:0] g2;

    ro_mux_n #(.N_CH(4)) u4 (
        .clk_ext(clk), .rstb(rstb), .en(en4), .mode(mode4),
        .ch_mask(mask4), .in(in4), .data_out(d4), .ch_id(ch4),
        .valid(v4), .frame_start(fs4), .gray(g4)
    );

    ro_mux_n #(.N_CH(2)) u2 (
        .clk_ext(clk), .rstb(rstb), .en(en2), .mode(mode2),
        .ch_mask(mask2), .in(in2), .data_out(d2), .ch_id(ch2),
        .valid(v2), .frame_start(fs2), .gray(g2)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] ch;
        logic       d;
        logic       v;
        logic       fs;
    } e4_t;

    typedef struct packed {
        logic [1:0] g;
        logic       ch;
        logic       d;
        logic       v;
        logic       fs;
    } e2_t;

    e4_t q4[$];
    e2_t q2[$];
    e4_t m4;
    e2_t m2;
    int  nvec = 0;
    int  nerr = 0;
    int  k4 = 0;
    int  k2 = 0;

    // Gray code of count 0..15 and trailing-zero owner of c' = 1..16.
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [1:0] gseq [16] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                              2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3};

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic e4(input logic [3:0] g, input logic [1:0] ch,
                      input logic d, input logic v, input logic fs);
        @(posedge clk);
        q4.push_back({g, ch, d, v, fs});
        #1;
    endtask

    task automatic e2(input logic [1:0] g, input logic ch,
                      input logic d, input logic v, input logic fs);
        @(posedge clk);
        q2.push_back({g, ch, d, v, fs});
        #1;
    endtask

    always @(negedge clk) begin
        if (q4.size() > 0) begin
            m4 = q4.pop_front();
            chk($sformatf("n4 edge %0d {g,ch,d,v,fs}", k4),
                16'({g4, ch4, d4, v4, fs4}), 16'(m4));
            k4++;
        end
        if (q2.size() > 0) begin
            m2 = q2.pop_front();
            chk($sformatf("n2 edge %0d {g,ch,d,v,fs}", k2),
                16'({g2, ch2, d2, v2, fs2}), 16'(m2));
            k2++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] c;
        logic       c2;
        int         t;

        rstb  = 1'b0;
        en4   = 1'b0; mode4 = 1'b0; mask4 = 4'hF; in4 = 4'h0;
        en2   = 1'b0; mode2 = 1'b0; mask2 = 2'b11; in2 = 2'b00;
        #12;
        chk("reset n4", 16'({g4, ch4, d4, v4, fs4}), 16'h0);
        chk("reset n2", 16'({g2, ch2, d2, v2, fs2}), 16'h0);
        rstb = 1'b1;
        #1;
        chk("release n4", 16'({g4, ch4, d4, v4, fs4}), 16'h0);

        // Full GRAY frame, all channels reported.
        en4 = 1'b1; mode4 = 1'b0; mask4 = 4'hF; in4 = 4'b1010;
        for (int i = 1; i <= 16; i++) begin
            c = gseq[4'(i - 1)];
            e4(gtab[4'(i)], c, in4[c], 1'b1, i == 16);
        end

        // Masked GRAY frame: only channels 0 and 2 valid.
        mask4 = 4'b0101; in4 = 4'b0110;
        for (int i = 1; i <= 16; i++) begin
            c = gseq[4'(i - 1)];
            e4(gtab[4'(i)], c, in4[c], mask4[c], i == 16);
        end

        // Mode request mid-frame, enable gap after edge 6.
        mask4 = 4'hF; in4 = 4'b0011;
        for (int i = 1; i <= 6; i++) begin
            c = gseq[4'(i - 1)];
            e4(gtab[4'(i)], c, in4[c], 1'b1, 1'b0);
            if (i == 5) mode4 = 1'b1;
        end
        en4 = 1'b0; in4 = 4'b1100;
        repeat (3) e4(4'b0101, 2'd1, 1'b1, 1'b0, 1'b0);
        en4 = 1'b1;
        for (int i = 7; i <= 16; i++) begin
            c = gseq[4'(i - 1)];
            e4(gtab[4'(i)], c, in4[c], 1'b1, i == 16);
        end
        for (int j = 1; j <= 8; j++) begin
            c = 2'(j % 4);
            e4(gtab[4'(j % 4)], c, in4[c], 1'b1, c == 2'd0);
            if (j == 6) mode4 = 1'b0;
        end

        // Back in GRAY; run to edge 9 then reset between edges.
        in4 = 4'b1010;
        for (int i = 1; i <= 9; i++) begin
            c = gseq[4'(i - 1)];
            e4(gtab[4'(i)], c, in4[c], 1'b1, 1'b0);
        end
        @(negedge clk);
        #1 rstb = 1'b0;
        #1 chk("async reset n4", 16'({g4, ch4, d4, v4, fs4}), 16'h0);
        mode4 = 1'b1; mask4 = 4'b1110; in4 = 4'b0001;
        #1 rstb = 1'b1;
        #1 chk("post reset n4", 16'({g4, ch4, d4, v4, fs4}), 16'h0);
        e4(4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
        e4(4'h3, 2'd1, 1'b0, 1'b1, 1'b0);
        en4 = 1'b0;

        // Two-channel instance: GRAY then RR.
        en2 = 1'b1; mode2 = 1'b0; mask2 = 2'b11; in2 = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            c2 = (i % 2 == 0);
            e2(gtab[4'(i % 4)][1:0], c2, in2[c2], 1'b1, i % 4 == 0);
            if (i == 5) mode2 = 1'b1;
        end
        mask2 = 2'b01;
        for (int j = 1; j <= 4; j++) begin
            c2 = (j % 2 == 1);
            e2({1'b0, c2}, c2, in2[c2], mask2[c2], !c2);
        end
        en2 = 1'b0;

        t = 0;
        while ((q4.size() + q2.size()) != 0 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("queue drain", 16'(q4.size() + q2.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ro_mux_n.md
RO_MUX_N -- requirements
Module: ro_mux_n

Interface
REQ-001 Parameter: N_CH, 8, number of readout channels; legal range 2..16.
REQ-002 Port: clk_ext  input  1  single global external clock; all state changes on its rising edge.
REQ-003 Port: rstb  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  advance enable; high = counter steps each clk_ext edge.
REQ-005 Port: mode  input  1  requested schedule: 0 = GRAY (binary-weighted slots), 1 = RR (equal round-robin).
REQ-006 Port: ch_mask  input  N_CH  per-channel report enable; bit k gates valid for channel k.
REQ-007 Port: in  input  N_CH  per-channel comparator outputs, sampled only in the owning slot.
REQ-008 Port: data_out  output  1  registered sample of the slot-owning channel.
REQ-009 Port: ch_id  output  $clog2(N_CH)  index of the channel whose sample is on data_out.
REQ-010 Port: valid  output  1  data_out/ch_id carry a new, unmasked sample this cycle.
REQ-011 Port: frame_start  output  1  one-cycle pulse: counter has just wrapped to 0.
REQ-012 Port: gray  output  N_CH  Gray-coded counter state, cnt ^ (cnt >> 1), registered.

Function
REQ-013 The block shall hold an N_CH-bit binary counter cnt and an active-mode register mode_act.
REQ-014 On an enabled edge, the block shall compute next count c' under mode_act: GRAY c' = (cnt+1) mod 2^N_CH; RR c' = (cnt+1) mod N_CH.
REQ-015 The slot owner k shall be: GRAY, k = trailing-zero count of c' if c' != 0, else k = N_CH-1 (the Gray bit that toggles); RR, k = c'.
REQ-016 On the same edge the block shall register cnt <= c', gray <= c' ^ (c' >> 1), ch_id <= k, data_out <= in[k], valid <= ch_mask[k].
REQ-017 Latency shall be zero cycles from the sampling edge: outputs after edge t reflect in[] at edge t.
REQ-018 frame_start shall be 1 for exactly the cycle following an enabled edge where c' = 0, else 0.
REQ-019 mode_act shall load mode only on an enabled edge where c' = 0; a mode change mid-frame shall take effect at the next frame boundary.
REQ-020 With en = 0: cnt, gray, mode_act, data_out and ch_id shall hold; valid and frame_start shall be 0.
REQ-021 GRAY frame length shall be 2^N_CH edges; channel k (k < N_CH-1) shall own 2^(N_CH-1-k) slots per frame and channel N_CH-1 shall own 2.
REQ-022 RR frame length shall be N_CH edges, one slot per channel.
REQ-023 A masked slot (ch_mask[k] = 0) shall still update ch_id and data_out but drive valid = 0.
REQ-024 Exactly one channel shall own each enabled edge; no slot shall be skipped or doubled.

Reset
REQ-025 While rstb = 0, asynchronously and regardless of clk_ext: cnt = 0, gray = 0, mode_act = GRAY, data_out = 0, ch_id = 0, valid = 0, frame_start = 0.
REQ-026 Reset asserted mid-frame shall abort the frame; the first enabled edge after release shall produce c' = 1, ch_id = (GRAY ? 0 : 1).
REQ-027 Reset release shall not itself generate frame_start or valid.

Structure
REQ-028 Shared package ro_pkg shall hold the mode constants RO_MODE_GRAY = 0 and RO_MODE_RR = 1 and the channel-index width function.
REQ-029 The trailing-zero slot decoder shall be a separate combinational sub-module ro_slot_dec (N_CH-bit in, index out, wrap-to-MSB on zero).
REQ-030 All registers shall reuse the asynchronous active-low reset flop style of the feedback library.

Verification (N_CH = 4 unless noted)
REQ-031 Reset, en=1, mode=0, mask=4'hF, in=4'b1010 -> ch_id over 16 edges 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3; data_out = in[ch_id]; frame_start only after edge 16.
REQ-032 mode raised to 1 after edge 5 -> GRAY sequence continues to edge 16, then ch_id 1,2,3,0 repeating, frame_start after every 4th edge.
REQ-033 mask=4'b0101 in GRAY -> valid high only when ch_id is 0 or 2 (10 of 16 edges); ch_id still follows REQ-031 sequence.
REQ-034 en low for 3 edges after edge 6 -> gray holds 4'b0101, valid = 0, frame_start = 0; sequence resumes with ch_id 0 at cnt 7.
REQ-035 rstb pulsed low mid-clock after edge 9 -> all outputs 0 immediately; next enabled edge gives cnt 1, ch_id 0, gray 4'b0001.
REQ-036 N_CH = 2, GRAY -> ch_id 0,1,0,1 with frame_start every 4th edge; RR -> ch_id 1,0 with frame_start every 2nd edge.
